// File: rtl/div_arb2.sv
// Two-requester round-robin front end for a shared sequential divider.
// It captures the winner's operands, starts the divider and returns the result with a one-cycle ack.
`ifndef m_M
`define m_M 8
`endif
`ifndef m_S
`define m_S 8
`endif

module div_arb2 #(
    parameter int WA  = `m_M,
    parameter int WB  = `m_S,
    parameter int TMO = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [WA-1:0] A0,
    input  logic [WA-1:0] A1,
    input  logic [WB-1:0] B0,
    input  logic [WB-1:0] B1,
    output logic          ack0,
    output logic          ack1,
    output logic [WA-1:0] res_Q,
    output logic [WB-1:0] res_F,
    output logic          err,
    output logic          busy,
    output logic [WA-1:0] div_A,
    output logic [WB-1:0] div_B,
    output logic          div_st,
    input  logic [WA-1:0] div_Q,
    input  logic [WB-1:0] div_F,
    input  logic          div_ok
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW       = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] WD_LAST  = CW'(TMO - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_wd;
    logic          r_win;
    logic          r_lg;

    logic          w_any;
    logic          w_tie;
    logic          w_sel;
    logic [WA-1:0] w_sel_a;
    logic [WB-1:0] w_sel_b;
    logic          w_b_zero;

    // Winner selection: a tie goes to the requester that did not win the last tie.
    always_comb begin
        w_any = req0 | req1;
        w_tie = req0 & req1;
        if (w_tie) begin
            w_sel = ~r_lg;
        end else if (req1) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
        if (w_sel) begin
            w_sel_a = A1;
            w_sel_b = B1;
        end else begin
            w_sel_a = A0;
            w_sel_b = B0;
        end
        w_b_zero = (w_sel_b == {WB{1'b0}});
    end

    // Sequencer state, watchdog and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wd    <= {CW{1'b0}};
            r_win   <= 1'b0;
            r_lg    <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            res_Q   <= {WA{1'b0}};
            res_F   <= {WB{1'b0}};
            err     <= 1'b0;
            busy    <= 1'b0;
            div_A   <= {WA{1'b0}};
            div_B   <= {WB{1'b0}};
            div_st  <= 1'b0;
        end else begin
            div_st <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win <= w_sel;
                        busy  <= 1'b1;
                        if (w_tie) begin
                            r_lg <= w_sel;
                        end
                        // A zero divisor is answered locally; the divider is never started.
                        if (w_b_zero) begin
                            res_Q   <= {WA{1'b1}};
                            res_F   <= {WB{1'b0}};
                            err     <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            div_A   <= w_sel_a;
                            div_B   <= w_sel_b;
                            div_st  <= 1'b1;
                            r_wd    <= {CW{1'b0}};
                            r_state <= S_BUSY;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_BUSY: begin
                    busy <= 1'b1;
                    if (div_ok) begin
                        res_Q   <= div_Q;
                        res_F   <= div_F;
                        err     <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_wd == WD_LAST) begin
                        res_Q   <= {WA{1'b0}};
                        res_F   <= {WB{1'b0}};
                        err     <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + CW'(1);
                    end
                end
                S_DONE: begin
                    ack0    <= ~r_win;
                    ack1    <= r_win;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
